// File: rtl/compare_arbiter.sv
// Round-robin arbiter that time-shares one magnitude comparator among N requesters.
// Each grant runs IDLE -> DRIVE -> DONE and returns the captured flags with a one-cycle Ack.
module compare_arbiter #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int IW = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [N-1:0]    Req,
    input  logic [N*W-1:0]  OpA,
    input  logic [N*W-1:0]  OpB,
    output logic [N-1:0]    Ack,
    output logic            ResGreater,
    output logic            ResEqual,
    output logic            ResLess,
    output logic [IW-1:0]   ResId,
    output logic            Busy,
    output logic            FlagErr,
    output logic [W-1:0]    CmpA,
    output logic [W-1:0]    CmpB,
    output logic            CmpEn,
    input  logic            CmpGreater,
    input  logic            CmpEqual,
    input  logic            CmpLess
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   win;
    logic [IW-1:0]   pos;
    logic            found;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [IW-1:0]   ptr_next;

    // Scan requesters starting at ptr, wrapping modulo N; the first hit wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = IW'((32'(ptr) + k) % N);
            if (!found && Req[pos]) begin
                found = 1'b1;
                win   = pos;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (IW'(k) == win) begin
                sel_a = OpA[k*W +: W];
                sel_b = OpB[k*W +: W];
            end
        end
    end

    assign ptr_next = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            Ack        <= '0;
            ResGreater <= 1'b0;
            ResEqual   <= 1'b0;
            ResLess    <= 1'b0;
            ResId      <= '0;
            Busy       <= 1'b0;
            FlagErr    <= 1'b0;
            CmpEn      <= 1'b0;
            CmpA       <= '0;
            CmpB       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Ack <= '0;
                    if (found) begin
                        CmpA  <= sel_a;
                        CmpB  <= sel_b;
                        CmpEn <= 1'b1;
                        idx   <= win;
                        Busy  <= 1'b1;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    ResGreater <= CmpGreater;
                    ResEqual   <= CmpEqual;
                    ResLess    <= CmpLess;
                    ResId      <= idx;
                    Ack        <= N'(1) << idx;
                    CmpEn      <= 1'b0;
                    CmpA       <= '0;
                    CmpB       <= '0;
                    if (!$onehot({CmpGreater, CmpEqual, CmpLess}))
                        FlagErr <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    Ack   <= '0;
                    ptr   <= ptr_next;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_compare_arbiter.sv
// Self-checking bench for compare_arbiter: directed vectors, corner sequences and a
// randomized run against a transaction-level round-robin/compare model.
module tb_compare_arbiter;

    logic        Clk;
    logic        Rst;
    logic [3:0]  Req;
    logic [15:0] OpA;
    logic [15:0] OpB;
    logic [3:0]  Ack;
    logic        ResGreater;
    logic        ResEqual;
    logic        ResLess;
    logic [1:0]  ResId;
    logic        Busy;
    logic        FlagErr;
    logic [3:0]  CmpA;
    logic [3:0]  CmpB;
    logic        CmpEn;
    logic        CmpGreater;
    logic        CmpEqual;
    logic        CmpLess;

    logic        bad;
    logic        exp_ferr;
    int          checks;
    int          errors;

    compare_arbiter #(.N(4), .W(4), .IW(2)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .OpA(OpA), .OpB(OpB), .Ack(Ack),
        .ResGreater(ResGreater), .ResEqual(ResEqual), .ResLess(ResLess),
        .ResId(ResId), .Busy(Busy), .FlagErr(FlagErr),
        .CmpA(CmpA), .CmpB(CmpB), .CmpEn(CmpEn),
        .CmpGreater(CmpGreater), .CmpEqual(CmpEqual), .CmpLess(CmpLess)
    );

    // Comparator stand-in; 'bad' makes it emit an illegal Greater+Equal pair.
    always_comb begin
        CmpGreater = 1'b0;
        CmpEqual   = 1'b0;
        CmpLess    = 1'b0;
        if (CmpEn) begin
            CmpGreater = bad ? 1'b1 : (CmpA > CmpB);
            CmpEqual   = bad ? 1'b1 : (CmpA == CmpB);
            CmpLess    = bad ? 1'b0 : (CmpA < CmpB);
        end
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        int          id;
        logic        g;
        logic        e;
        logic        l;
    } vec_t;

    vec_t tbl [6];

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset;
        Rst = 1'b1;
        Req = '0;
        tick;
        tick;
        Rst = 1'b0;
        exp_ferr = 1'b0;
    endtask

    // One full grant starting with the DUT in IDLE; Req is dropped once Ack is seen.
    task automatic do_txn(input logic [3:0] req, input logic [15:0] a, input logic [15:0] b,
                          input int eid, input logic eg, input logic ee, input logic el);
        logic [3:0] ea;
        logic [3:0] eb;
        ea  = a[eid*4 +: 4];
        eb  = b[eid*4 +: 4];
        Req = req;
        OpA = a;
        OpB = b;
        tick;
        chk("drive_cmpen", CmpEn, 1);
        chk("drive_cmpa", CmpA, ea);
        chk("drive_cmpb", CmpB, eb);
        chk("drive_busy", Busy, 1);
        chk("drive_ack", Ack, 0);
        OpA = ~a;
        OpB = ~b;
        tick;
        if (bad) exp_ferr = 1'b1;
        chk("done_ack", Ack, 4'b0001 << eid);
        chk("done_resid", ResId, eid);
        chk("done_greater", ResGreater, eg);
        chk("done_equal", ResEqual, ee);
        chk("done_less", ResLess, el);
        chk("done_busy", Busy, 1);
        chk("done_cmpen", CmpEn, 0);
        chk("done_flagerr", FlagErr, exp_ferr);
        Req = '0;
        tick;
        chk("idle_busy", Busy, 0);
        chk("idle_ack", Ack, 0);
    endtask

    function automatic int model_pick(input logic [3:0] req, input int ptr);
        for (int off = 0; off < 4; off++)
            if (req[(ptr + off) % 4]) return (ptr + off) % 4;
        return -1;
    endfunction

    initial begin
        int          mptr;
        int          w;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [3:0]  rr;
        logic [3:0]  av;
        logic [3:0]  bv;
        logic        prev_en;
        int          exp_ack;

        checks   = 0;
        errors   = 0;
        bad      = 1'b0;
        exp_ferr = 1'b0;
        Rst      = 1'b1;
        Req      = 4'b1111;
        OpA      = '0;
        OpB      = '0;

        tbl[0] = '{4'b0100, 16'h0900, 16'h0500, 2, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{4'b0001, 16'h0003, 16'h0003, 0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{4'b0001, 16'h0002, 16'h000C, 0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{4'b1001, 16'hF000, 16'h0000, 3, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{4'b1001, 16'h0007, 16'h0007, 0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{4'b0011, 16'h0000, 16'h0010, 1, 1'b0, 1'b0, 1'b1};

        // Reset held with all requests pending
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("rst_ack", Ack, 0);
            chk("rst_cmpen", CmpEn, 0);
            chk("rst_busy", Busy, 0);
            chk("rst_flagerr", FlagErr, 0);
        end
        Rst = 1'b0;
        Req = '0;

        for (int i = 0; i < 6; i++)
            do_txn(tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].id, tbl[i].g, tbl[i].e, tbl[i].l);

        // Constant full request from Ptr=0: grants 0,1,2,3,0 at cycles 2,5,8,11,14
        do_reset;
        OpA     = 16'h4321;
        OpB     = 16'h2222;
        Req     = 4'b1111;
        prev_en = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick;
            exp_ack = (c % 3 == 2) ? (1 << (((c - 2) / 3) % 4)) : 0;
            chk("rr_ack", Ack, exp_ack);
            chk("rr_cmpen_gap", prev_en & CmpEn, 0);
            prev_en = CmpEn;
        end
        Req = '0;
        tick;

        // Reset during DRIVE, then re-arbitration from index 0
        do_reset;
        Req = 4'b0100;
        OpA = 16'h0900;
        OpB = 16'h0500;
        tick;
        chk("rstmid_drive_cmpen", CmpEn, 1);
        Rst = 1'b1;
        Req = 4'b0110;
        OpA = 16'h0050;
        OpB = 16'h0030;
        tick;
        chk("rstmid_ack", Ack, 0);
        chk("rstmid_cmpen", CmpEn, 0);
        chk("rstmid_busy", Busy, 0);
        Rst = 1'b0;
        tick;
        chk("rstmid_regrant_cmpen", CmpEn, 1);
        chk("rstmid_regrant_cmpa", CmpA, 5);
        tick;
        chk("rstmid_regrant_ack", Ack, 4'b0010);
        chk("rstmid_regrant_greater", ResGreater, 1);
        Req = '0;
        tick;

        // Illegal comparator flags: sticky error until reset
        do_reset;
        bad = 1'b1;
        do_txn(4'b0001, 16'h0003, 16'h0003, 0, 1'b1, 1'b1, 1'b0);
        bad = 1'b0;
        do_txn(4'b0010, 16'h0040, 16'h0090, 1, 1'b0, 1'b0, 1'b1);
        do_reset;
        chk("flagerr_cleared", FlagErr, 0);

        // Randomized transactions against the model
        do_reset;
        mptr = 0;
        for (int i = 0; i < 40; i++) begin
            rr = 4'($urandom_range(1, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            w  = model_pick(rr, mptr);
            av = ra[w*4 +: 4];
            bv = rb[w*4 +: 4];
            do_txn(rr, ra, rb, w, av > bv, av == bv, av < bv);
            mptr = (w + 1) % 4;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
